// File: rtl/counter_pkg.sv
// Shared types and defaults for the modulo up/down counter.
// The mode enum is one bit so it maps directly onto the external mode pin.
package counter_pkg;

  localparam int CNT_WIDTH_DEF = 4;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

endpackage

// File: rtl/cnt_boundary_det.sv
// Combinational boundary detector and next-count generator for the counter.
// Increment/decrement happen only away from the boundary, so no value ever relies on 2**WIDTH rollover.
module cnt_boundary_det
  import counter_pkg::*;
#(
  parameter int              WIDTH = CNT_WIDTH_DEF,
  parameter logic [WIDTH-1:0] MAX_C = '1
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  input  cnt_mode_e        mode,
  output logic             at_bound,
  output logic [WIDTH-1:0] next_cnt
);

  always_comb begin
    at_bound = up_dn ? (count == MAX_C) : (count == '0);
    next_cnt = count;
    if (at_bound) begin
      if (mode == CNT_WRAP) begin
        next_cnt = up_dn ? '0 : MAX_C;
      end
    end else if (up_dn) begin
      next_cnt = count + WIDTH'(1);
    end else begin
      next_cnt = count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with parallel load, wrap/saturate boundary mode,
// a registered terminal-count pulse and a sticky saturation-overflow flag.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH   = CNT_WIDTH_DEF,
  parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_C = MAX_VAL[WIDTH-1:0];

  cnt_mode_e        mode_e;
  logic             at_bound;
  logic [WIDTH-1:0] next_cnt;
  logic [WIDTH-1:0] load_clamped;
  logic             bound_evt;
  logic             sat_evt;

  assign mode_e       = cnt_mode_e'(mode);
  assign load_clamped = (load_val > MAX_C) ? MAX_C : load_val;
  // Load outranks enable, so a load cycle is never a boundary event.
  assign bound_evt    = en & ~load & at_bound;
  assign sat_evt      = bound_evt & (mode_e == CNT_SAT);

  cnt_boundary_det #(
    .WIDTH (WIDTH),
    .MAX_C (MAX_C)
  ) u_bdet (
    .count    (count),
    .up_dn    (up_dn),
    .mode     (mode_e),
    .at_bound (at_bound),
    .next_cnt (next_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_clamped;
    end else if (en) begin
      count <= next_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tc <= 1'b0;
    end else begin
      tc <= bound_evt;
    end
  end

  // Set wins over clear when both land on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (sat_evt) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: MAX_VAL=9 and MAX_VAL=1 instances share stimulus
// and are compared every cycle against an integer reference model.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, mode, load, clr_ovf;
  logic [3:0] load_val;
  logic [3:0] count_a, count_b;
  logic       tc_a, tc_b, ovf_a, ovf_b;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_q[$];
  int         mx[2]    = '{9, 1};
  int         m_cnt[2];
  bit         m_tc[2];
  bit         m_ovf[2];

  // clock/reset block
  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MAX_VAL(9)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf), .count(count_a), .tc(tc_a), .ovf(ovf_a)
  );

  mod_updown_counter #(.WIDTH(4), .MAX_VAL(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf), .count(count_b), .tc(tc_b), .ovf(ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one rising edge, written from the counting rules.
  task automatic ref_step(input int i);
    int  c;
    bit  hit;
    bit  set_ovf;
    c       = m_cnt[i];
    hit     = 1'b0;
    set_ovf = 1'b0;
    if (!rst) begin
      m_cnt[i] = 0;
      m_tc[i]  = 1'b0;
      m_ovf[i] = 1'b0;
      return;
    end
    if (load) begin
      m_cnt[i] = (int'(load_val) > mx[i]) ? mx[i] : int'(load_val);
    end else if (en) begin
      if (up_dn) begin
        if (c == mx[i]) hit = 1'b1;
        else m_cnt[i] = c + 1;
      end else begin
        if (c == 0) hit = 1'b1;
        else m_cnt[i] = c - 1;
      end
      if (hit) begin
        if (mode) set_ovf = 1'b1;
        else m_cnt[i] = up_dn ? 0 : mx[i];
      end
    end
    m_tc[i] = hit;
    if (set_ovf) m_ovf[i] = 1'b1;
    else if (clr_ovf) m_ovf[i] = 1'b0;
  endtask

  // Driver: apply inputs, take one edge, compare both instances #1 later.
  task automatic step(input bit r, input bit e, input bit u, input bit m,
                      input bit l, input logic [3:0] lv, input bit c);
    rst = r; en = e; up_dn = u; mode = m; load = l; load_val = lv; clr_ovf = c;
    @(posedge clk);
    ref_step(0);
    ref_step(1);
    exp_q.push_back(4'(m_cnt[0]));
    #1;
    check("count_a", 32'(count_a), 32'(exp_q.pop_front()));
    check("tc_a",    32'(tc_a),    32'(m_tc[0]));
    check("ovf_a",   32'(ovf_a),   32'(m_ovf[0]));
    check("count_b", 32'(count_b), 32'(m_cnt[1]));
    check("tc_b",    32'(tc_b),    32'(m_tc[1]));
    check("ovf_b",   32'(ovf_b),   32'(m_ovf[1]));
  endtask

  initial begin
    m_cnt = '{0, 0};
    m_tc  = '{0, 0};
    m_ovf = '{0, 0};

    // reset two cycles
    step(0, 1, 1, 1, 0, 4'd0, 0);
    step(0, 0, 0, 0, 1, 4'd5, 0);
    check("rst_count", 32'(count_a), 32'd0);

    // wrap up 0..9,0 (instance b toggles 0,1,0,1)
    for (int k = 0; k < 10; k++) step(1, 1, 1, 0, 0, 4'd0, 0);
    check("wrap_up_zero", 32'(count_a), 32'd0);
    check("wrap_up_tc", 32'(tc_a), 32'd1);

    // load 2, count down through wrap 1,0,9,8
    step(1, 0, 0, 0, 1, 4'd2, 0);
    for (int k = 0; k < 4; k++) step(1, 1, 0, 0, 0, 4'd0, 0);
    check("wrap_dn_val", 32'(count_a), 32'd8);

    // saturate up from 7, then clear ovf while idle
    step(1, 0, 1, 1, 1, 4'd7, 0);
    for (int k = 0; k < 5; k++) step(1, 1, 1, 1, 0, 4'd0, 0);
    check("sat_hold", 32'(count_a), 32'd9);
    check("sat_ovf", 32'(ovf_a), 32'd1);
    step(1, 0, 1, 1, 0, 4'd0, 1);
    check("clr_ovf", 32'(ovf_a), 32'd0);

    // clamped load, load beats enable
    step(1, 0, 1, 0, 1, 4'd15, 0);
    check("load_clamp", 32'(count_a), 32'd9);
    step(1, 1, 1, 0, 1, 4'd3, 0);
    check("load_over_en", 32'(count_a), 32'd3);

    // reset while count=6 and ovf=1, then resume counting
    step(1, 0, 1, 1, 1, 4'd9, 0);
    step(1, 1, 1, 1, 0, 4'd0, 0);
    step(1, 0, 1, 1, 1, 4'd6, 0);
    step(0, 1, 1, 1, 0, 4'd0, 0);
    check("rst_mid_ovf", 32'(ovf_a), 32'd0);
    for (int k = 0; k < 3; k++) step(1, 1, 1, 0, 0, 4'd0, 0);
    check("resume", 32'(count_a), 32'd3);

    // set and clear of ovf on the same edge
    step(1, 0, 1, 1, 1, 4'd9, 0);
    step(1, 1, 1, 1, 0, 4'd0, 1);
    check("set_clr_ovf", 32'(ovf_b), 32'd1);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 24) != 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 5) == 0));
    end

    if (exp_q.size() != 0) check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
